// File: rtl/booth_multiplier32.sv
// booth_multiplier32
//   Sequential signed radix-2 Booth multiplier for the ALU datapath. It
//   performs one Booth iteration per clock. The full 2*WIDTH-bit product
//   is packed as {hi,lo}, which matches the divider's {remainder,quotient}
//   packing.
//
// Ports
//   clk           system clock; all state updates on the rising edge
//   reset         asynchronous, active-high; clears all state immediately
//   start         operation request, accepted only while busy is low
//   multiplicand  signed operand M, captured on the accepting edge
//   multiplier    signed operand Q, captured on the accepting edge
//   busy          high while iterations are in progress
//   done          one-cycle pulse when product becomes valid
//   product       signed {hi,lo} result, held until the next completion
//   overflow      present only when MUL_OVERFLOW_FLAG_EN is defined; set when
//                 the result does not fit in the signed lo half
//
// Optional feature macro: MUL_OVERFLOW_FLAG_EN
module booth_multiplier32 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
`ifdef MUL_OVERFLOW_FLAG_EN
    output logic               overflow,
`endif
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // The accumulator is one bit wider than the operands, so negating
    // M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]     m_reg;
    logic [WIDTH:0]     a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q_1;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     a_sum;
    logic [WIDTH:0]     a_next;
    logic [WIDTH-1:0]   q_next;
    logic [CW-1:0]      count_next;
    logic [2*WIDTH-1:0] product_next;
    logic               last_step;

    // One Booth step: add or subtract M according to the current bit pair,
    // then arithmetic-shift {A,Q,q_1} right by one bit.
    always_comb begin
        a_sum = a_reg;
        unique case ({q_reg[0], q_1})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        a_next       = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next       = {a_sum[0], q_reg[WIDTH-1:1]};
        count_next   = count + 1'b1;
        last_step    = (count_next == LAST_COUNT);
        product_next = {a_next[WIDTH-1:0], q_next};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A start request is honoured only from IDLE, so a
    // request made while busy is ignored.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start)     next_state = BUSY;
            BUSY: if (last_step) next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

    // Datapath registers. Operands are captured only on the accepting edge.
    // The product register changes only on the completion edge, so it never
    // shows partial values and holds through any following operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg    <= '0;
            a_reg    <= '0;
            q_reg    <= '0;
            q_1      <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            product  <= '0;
`ifdef MUL_OVERFLOW_FLAG_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= {multiplicand[WIDTH-1], multiplicand};
                        a_reg <= '0;
                        q_reg <= multiplier;
                        q_1   <= 1'b0;
                        count <= '0;
                    end
                end
                BUSY: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_1   <= q_reg[0];
                    count <= count_next;
                    if (last_step) begin
                        product  <= product_next;
                        done     <= 1'b1;
`ifdef MUL_OVERFLOW_FLAG_EN
                        overflow <= (product_next[2*WIDTH-1:WIDTH] !=
                                     {WIDTH{product_next[WIDTH-1]}});
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier32.sv
// tb_booth_multiplier32
//   Directed bench for booth_multiplier32 with WIDTH=32. The test has two
//   parts:
//   - A table of operand pairs, each with a hand-computed product and
//     overflow flag.
//   - Hand-written sequences covering the ignored start, a start in the
//     done cycle, and an asynchronous reset mid-operation.
//   Overflow checks are compiled in when MUL_OVERFLOW_FLAG_EN is defined.
module tb_booth_multiplier32;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef MUL_OVERFLOW_FLAG_EN
    logic           overflow;
`endif

    int vectorCount;
    int missCount;

    booth_multiplier32 #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
`ifdef MUL_OVERFLOW_FLAG_EN
        .overflow     (overflow),
`endif
        .product      (product)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] expProduct;
        logic           expOverflow;
    } vec_t;

    vec_t vecs[10];

    // Compare one value against its expectation and count the result.
    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present operands with start high for one rising edge. Return at the
    // falling edge after the accepting edge, with start already dropped.
    task automatic startOp(input logic [W-1:0] m, input logic [W-1:0] q);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample on falling edges until done is seen, with a bounded wait.
    // Return the falling edges elapsed and how many of them had busy high.
    task automatic waitDone(input string name, output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (!done && cycles < 200) begin
            if (busy) busyCycles++;
            cycles++;
            @(negedge clk);
        end
        if (!done) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL %s timeout: done not seen after %0d cycles, expected within 32", name, cycles);
        end
    endtask

    // Run one table entry through the multiplier, then check the product,
    // the done latency and the number of cycles with busy high.
    task automatic applyStimulus(input int idx);
        int cycles;
        int busyCycles;
        startOp(vecs[idx].m, vecs[idx].q);
        waitDone($sformatf("vec%0d", idx), cycles, busyCycles);
        checkOutput($sformatf("vec%0d product", idx), product, vecs[idx].expProduct);
        checkOutput($sformatf("vec%0d latency", idx), 64'(cycles), 64'd32);
        checkOutput($sformatf("vec%0d busy cycles", idx), 64'(busyCycles), 64'd32);
`ifdef MUL_OVERFLOW_FLAG_EN
        checkOutput($sformatf("vec%0d overflow", idx), 64'(overflow), 64'(vecs[idx].expOverflow));
`endif
    endtask

    initial begin
        int cycles;
        int busyCycles;

        vectorCount  = 0;
        missCount    = 0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Each entry: {multiplicand, multiplier, expected product, expected overflow}.
        vecs[0] = '{32'hFFFF_FFFD, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0}; // -3 x 2
        vecs[1] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'h0000_0000_0000_000E, 1'b0}; // -7 x -2
        vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFB, 64'h0000_0000_0000_0000, 1'b0}; // 0 x -5
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};
        vecs[5] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}; // -1 x 1
        vecs[8] = '{32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_000F, 1'b0};
        vecs[9] = '{32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, 1'b1}; // -1 x -2^31

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset product", product, 64'd0);
`ifdef MUL_OVERFLOW_FLAG_EN
        checkOutput("reset overflow", 64'(overflow), 64'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(i);
        end

        // A start pulse while busy must be ignored, including its operands.
        startOp(32'd5, 32'd3);
        repeat (9) @(negedge clk);
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignored start", cycles, busyCycles);
        checkOutput("ignored start product", product, 64'h0000_0000_0000_000F);

        // A start in the done cycle is accepted while the old product holds.
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("done-cycle start busy", 64'(busy), 64'd1);
        checkOutput("done-cycle start done", 64'(done), 64'd0);
        checkOutput("product held", product, 64'h0000_0000_0000_000F);
        waitDone("done-cycle start", cycles, busyCycles);
        checkOutput("done-cycle start product", product, 64'h0000_0000_0000_0004);
        checkOutput("done-cycle start latency", 64'(cycles), 64'd32);

        // Asynchronous reset mid-operation must clear outputs before any clock edge.
        startOp(32'hFFFF_FFFD, 32'h0000_0002);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset done", 64'(done), 64'd0);
        checkOutput("async reset product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        startOp(32'd4, 32'd4);
        waitDone("after reset", cycles, busyCycles);
        checkOutput("after reset product", product, 64'h0000_0000_0000_0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
